serial_mag_cmp_ctrl: RTL and testbench



---
 rtl/serial_mag_cmp_ctrl.sv | 103 ++++++++++
 tb/tb_serial_mag_cmp_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp_ctrl.sv
// Multi-cycle unsigned magnitude comparator: one SLICE-bit compare slice is stepped
// LSB-first across the captured operands, cascading lt/eq/gt through a register.
module serial_mag_cmp_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (SLICE < 1 || (WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_params
      $error("serial_mag_cmp_ctrl: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx_reg;
  logic [2:0]       casc_reg;   // {L,E,G} result of the slices below idx_reg

  logic [SLICE-1:0] a_sl [NSLICE];
  logic [SLICE-1:0] b_sl [NSLICE];
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [2:0]       slice_res;
  logic             last_slice;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slices
      assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
    end
  endgenerate

  // A differing slice decides outright; an equal slice defers to the lower slices.
  always_comb begin
    sa        = a_sl[idx_reg];
    sb        = b_sl[idx_reg];
    slice_res = casc_reg;
    if (sa < sb)      slice_res = 3'b100;
    else if (sa > sb) slice_res = 3'b001;
    last_slice = (idx_reg == IW'(NSLICE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      idx_reg      <= '0;
      casc_reg     <= 3'b000;
      busy         <= 1'b0;
      done         <= 1'b0;
      {lt, eq, gt} <= 3'b000;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg        <= a;
            b_reg        <= b;
            casc_reg     <= 3'b010;
            idx_reg      <= '0;
            {lt, eq, gt} <= 3'b000;
            busy         <= 1'b1;
            state_reg    <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          casc_reg <= slice_res;
          if (last_slice) begin
            {lt, eq, gt} <= slice_res;
            done         <= 1'b1;
            busy         <= 1'b0;
            state_reg    <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Directed self-checking bench for serial_mag_cmp_ctrl (WIDTH=16, SLICE=4).
module tb_serial_mag_cmp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        lt;
  logic        eq;
  logic        gt;

  int checks = 0;
  int errors = 0;
  logic saw_done;

  serial_mag_cmp_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs and samples are taken 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-20s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input logic eb, input logic ed, input logic [2:0] er);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".res"},  32'({lt, eq, gt}), 32'(er));
  endtask

  // Issue one comparison from IDLE and check the done cycle (cycle 5).
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic [2:0] er);
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_state($sformatf("%s.c%0d", tag, c), 1'b1, 1'b0, 3'b000);
      tick();
    end
    chk_state({tag, ".done"}, 1'b0, 1'b1, er);
    tick();
    chk_state({tag, ".hold"}, 1'b0, 1'b0, er);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk_state("reset", 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    tick();
    chk_state("idle", 1'b0, 1'b0, 3'b000);

    run_op("t1_eq", 16'h1234, 16'h1234, 3'b010);
    run_op("t2_gt", 16'h8000, 16'h7FFF, 3'b001);
    run_op("t3_lt", 16'h1230, 16'h1231, 3'b100);

    // Second start while running must be ignored.
    a = 16'd1; b = 16'd2; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick();                                   // cycle 2
    a = 16'd5; b = 16'd3; start = 1'b1;
    tick();                                   // cycle 3
    start = 1'b0;
    chk_state("t4.c3", 1'b1, 1'b0, 3'b000);
    tick(); tick();                           // cycle 5
    chk_state("t4.done", 1'b0, 1'b1, 3'b100);
    tick();
    chk_state("t4.c6", 1'b0, 1'b0, 3'b100);
    tick();
    chk_state("t4.c7", 1'b0, 1'b0, 3'b100);

    // Reset mid-run aborts without a done pulse.
    a = 16'hABCD; b = 16'h0001; start = 1'b1;
    tick();                                   // cycle 1
    start = 1'b0;
    tick(); tick();                           // cycle 3
    rst = 1'b1;
    tick();                                   // cycle 4
    chk_state("t5.rst", 1'b0, 1'b0, 3'b000);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("t5.no_done", 32'(saw_done), 32'd0);
    chk_state("t5.idle", 1'b0, 1'b0, 3'b000);

    // Back-to-back with start held high.
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    tick();                                   // cycle 1
    tick(); tick(); tick(); tick();           // cycle 5
    chk_state("t6.done1", 1'b0, 1'b1, 3'b001);
    a = 16'h0000; b = 16'hFFFF;
    for (int c = 6; c <= 9; c++) begin
      tick();
      chk_state($sformatf("t6.c%0d", c), 1'b1, 1'b0, 3'b000);
    end
    tick();                                   // cycle 10
    chk_state("t6.done2", 1'b0, 1'b1, 3'b100);
    start = 1'b0;
    tick();
    chk_state("t6.idle", 1'b0, 1'b0, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
